// File: rtl/dx_stage_if.sv
// Bundle of decode-side inputs and execute-side outputs of the D/X pipeline register.
// The decode/fetch side drives through master; dx_stage consumes through slave.
interface dx_stage_if;
  logic [31:0] IR_FD;
  logic [31:0] PC_FD;
  logic [31:0] regA_fd;
  logic [31:0] regB_fd;
  logic [31:0] ctrl_fd;
  logic [4:0]  rt_fd;
  logic        rt_used_fd;
  logic        is_md_fd;
  logic        flush;
  logic        md_ready;
  logic [31:0] IR_DX;
  logic [31:0] PC_DX;
  logic [31:0] A_DX;
  logic [31:0] B_DX;
  logic [31:0] ctrl_dx;
  logic        stall_fd;
  logic        dx_hold;
  logic        md_start;

  modport master (
    output IR_FD, PC_FD, regA_fd, regB_fd, ctrl_fd, rt_fd, rt_used_fd,
           is_md_fd, flush, md_ready,
    input  IR_DX, PC_DX, A_DX, B_DX, ctrl_dx, stall_fd, dx_hold, md_start
  );

  modport slave (
    input  IR_FD, PC_FD, regA_fd, regB_fd, ctrl_fd, rt_fd, rt_used_fd,
           is_md_fd, flush, md_ready,
    output IR_DX, PC_DX, A_DX, B_DX, ctrl_dx, stall_fd, dx_hold, md_start
  );
endinterface

// File: rtl/dx_stage.sv
// Decode-to-execute pipeline register with load-use stall, flush bubbles and
// a mult/div hold state that freezes DX until the functional unit reports ready.
module dx_stage #(
  parameter logic [31:0] NOP_IR   = 32'd0,
  parameter logic [31:0] NOP_CTRL = 32'd0
) (
  input  logic       clock,
  input  logic       reset_n,
  dx_stage_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_ir, r_pc, r_a, r_b, r_ctrl;
  logic [31:0] w_ir_next, w_pc_next, w_a_next, w_b_next, w_ctrl_next;
  logic        r_md_start, w_md_start_next;
  logic        w_lu, w_advance, w_stall, w_hold;
  logic [4:0]  w_dx_rd;

  // Load in DX writing a nonzero register that the FD instruction reads.
  assign w_dx_rd = r_ctrl[31:27];
  assign w_lu    = r_ctrl[13] & r_ctrl[15] & (w_dx_rd != 5'd0) &
                   ((w_dx_rd == bus.ctrl_fd[5:1]) |
                    (bus.rt_used_fd & (w_dx_rd == bus.rt_fd)));

  // MD_WAIT only advances once the unit is ready; a stray flush still wins.
  assign w_advance = (r_state == RUN) | bus.md_ready | bus.flush;

  always_comb begin
    w_state_next    = r_state;
    w_ir_next       = r_ir;
    w_pc_next       = r_pc;
    w_a_next        = r_a;
    w_b_next        = r_b;
    w_ctrl_next     = r_ctrl;
    w_md_start_next = 1'b0;
    w_stall         = 1'b0;
    w_hold          = 1'b0;

    if (r_state == RUN) begin
      w_stall = w_lu & ~bus.flush;
    end else begin
      w_stall = ~bus.md_ready;
      w_hold  = ~bus.md_ready;
    end

    if (w_advance) begin
      if (bus.flush | w_lu) begin
        w_ir_next    = NOP_IR;
        w_pc_next    = 32'd0;
        w_a_next     = 32'd0;
        w_b_next     = 32'd0;
        w_ctrl_next  = NOP_CTRL;
        w_state_next = RUN;
      end else begin
        w_ir_next       = bus.IR_FD;
        w_pc_next       = bus.PC_FD;
        w_a_next        = bus.regA_fd;
        w_b_next        = bus.regB_fd;
        w_ctrl_next     = bus.ctrl_fd;
        w_md_start_next = bus.is_md_fd;
        w_state_next    = bus.is_md_fd ? MD_WAIT : RUN;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ir       <= NOP_IR;
      r_pc       <= 32'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_ctrl     <= NOP_CTRL;
      r_md_start <= 1'b0;
    end else begin
      r_ir       <= w_ir_next;
      r_pc       <= w_pc_next;
      r_a        <= w_a_next;
      r_b        <= w_b_next;
      r_ctrl     <= w_ctrl_next;
      r_md_start <= w_md_start_next;
    end
  end

  assign bus.IR_DX    = r_ir;
  assign bus.PC_DX    = r_pc;
  assign bus.A_DX     = r_a;
  assign bus.B_DX     = r_b;
  assign bus.ctrl_dx  = r_ctrl;
  assign bus.stall_fd = w_stall;
  assign bus.dx_hold  = w_hold;
  assign bus.md_start = r_md_start;

endmodule

// File: doc/dx_stage.md
Name: dx_stage

Overview:
- Decode-to-execute pipeline register for the 5-stage CPU.
- Registers IR, PC, operand data and the 32-bit control word from decode. It is the sole producer of IR_DX and ctrl_dx, which the bypass unit consumes.
- Owns hazard-driven sequencing: load-use stall, branch/jump flush, and multi-cycle mult/div hold.

Parameters:
- NOP_IR, 32'd0, instruction word inserted as a bubble.
- NOP_CTRL, 32'd0, control word inserted as a bubble (RWE=0, Dmem_WE=0).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- IR_FD  in  32  instruction leaving the fetch/decode latch.
- PC_FD  in  32  PC of IR_FD.
- regA_fd  in  32  regfile read data for rs.
- regB_fd  in  32  regfile read data for rt.
- ctrl_fd  in  32  decode control word; same bit map as ctrl_dx (31:27 rd, 15 RWE, 13 mem_to_reg, 5:1 rs).
- rt_fd  in  5  decoded rt of IR_FD.
- rt_used_fd  in  1  IR_FD reads rt.
- is_md_fd  in  1  IR_FD is mul or div.
- flush  in  1  branch/jump taken, resolved in X this cycle.
- md_ready  in  1  mult/div result valid this cycle.
- IR_DX  out  32  registered instruction.
- PC_DX  out  32  registered PC.
- A_DX  out  32  registered operand A.
- B_DX  out  32  registered operand B.
- ctrl_dx  out  32  registered control word.
- stall_fd  out  1  hold PC and the F/D latch this cycle.
- dx_hold  out  1  DX is held; XM latch must load a bubble.
- md_start  out  1  one-cycle pulse to launch mult/div.

Behaviour:
- Reset (async, reset_n=0):
  - IR_DX=NOP_IR, ctrl_dx=NOP_CTRL; PC_DX, A_DX and B_DX are 0.
  - stall_fd=0, dx_hold=0, md_start=0; state=RUN.
- States: RUN, MD_WAIT. The load-use stall is combinational within RUN, so no extra state is needed.
- Load-use hazard (lu):
  - Condition: ctrl_dx[13] & ctrl_dx[15] & (ctrl_dx[31:27] != 0), AND either (ctrl_dx[31:27] == ctrl_fd[5:1]) or (rt_used_fd & ctrl_dx[31:27] == rt_fd).
- Outputs in RUN:
  - stall_fd = lu & ~flush.
  - dx_hold = 0.
- Outputs in MD_WAIT:
  - stall_fd = ~md_ready.
  - dx_hold = ~md_ready.
- Clock edge in RUN, first matching rule wins:
  1. flush: load bubble; state RUN. Flush dominates lu.
  2. lu: load bubble; state RUN. F/D is held by stall_fd, so on the next cycle the same IR_FD re-evaluates, and lu is now false because ctrl_dx is the bubble.
  3. Otherwise: load all FD inputs. If is_md_fd=1, state goes to MD_WAIT and md_start=1 for the following cycle only.
- Clock edge in MD_WAIT:
  - md_start is 0 after its first cycle.
  - md_ready=0: all DX registers hold their values.
  - md_ready=1: behave exactly as in RUN for that edge, then leave MD_WAIT. If the incoming instruction is also mul/div, re-enter MD_WAIT with a new md_start pulse.
  - flush is never asserted in MD_WAIT, because a mul/div instruction cannot redirect. If it does occur, treat it as in RUN: bubble, state RUN, held result abandoned.
- md_ready already high in the md_start cycle: the mult/div completes with a single hold-free cycle.
- Bubble: IR_DX=NOP_IR, ctrl_dx=NOP_CTRL; PC_DX, A_DX and B_DX load 0.
- Latency: one cycle FD→DX when not stalled.
- Reset mid-operation: reset_n low in MD_WAIT forces RUN and drops md_start immediately.
- Destination r0: never triggers lu.

Test Plan:
- Plain flow: add r3,r1,r2 in FD → next edge IR_DX equals that IR, ctrl_dx=ctrl_fd, stall_fd=0 throughout.
- Load-use: lw r5 in DX (ctrl_dx[13]=1, rd=5), FD add rs=5 →
  - stall_fd=1 for exactly 1 cycle and IR_DX becomes 0.
  - The add enters DX one cycle later.
- Load-use false cases, no stall:
  - lw r0 followed by a reader of r0.
  - lw r5 followed by FD with rt_fd=5 and rt_used_fd=0.
- Flush vs lu: lu true and flush=1 in the same cycle → bubble loaded, stall_fd=0, FD advances.
- Mult/div: mul in FD →
  - md_start=1 one cycle after entry.
  - dx_hold=1 and stall_fd=1 while md_ready=0 (hold 4 cycles).
  - At md_ready=1 the next instruction enters DX on that edge.
- Back-to-back mul/div: two consecutive mul instructions → two md_start pulses, each followed by its own MD_WAIT.
- Reset while in MD_WAIT (reset_n=0 mid-hold) → all outputs 0 asynchronously, state RUN.
